// File: rtl/hilo_mul_unit.sv
// MULT/MULTU sequencing and HI/LO register unit.
// Feeds operand magnitudes to an external combinational unsigned array
// multiplier. Holds them for LATENCY cycles, then samples the product,
// restores the sign for MULT and commits it to HI/LO. MTHI/MTLO write the
// registers directly while the unit is idle.
module hilo_mul_unit #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_p,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    // 4 bits covers the LATENCY-1 = 15 worst case
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_mul_x;
    logic [31:0]        r_mul_y;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [63:0]        w_result;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000, which is
    // exactly its magnitude when read as unsigned.
    function automatic logic [31:0] mag32(input logic signed [31:0] a);
        logic [31:0] u;
        u = a;
        return a[31] ? (~u + 32'd1) : u;
    endfunction

    // Sign restoration on the unsigned product. The magnitude never
    // exceeds 2^62, so this cannot overflow; -0 comes back as 0.
    function automatic logic [63:0] apply_sign64(input logic [63:0] p,
                                                 input logic        neg);
        return neg ? (~p + 64'd1) : p;
    endfunction

    assign w_result = apply_sign64(mul_p, r_neg);

    // Control FSM, operand registers and HI/LO, all in one clocked block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mul_x <= '0;
            r_mul_y <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                r_mul_x <= mag32(rs_val);
                                r_mul_y <= mag32(rt_val);
                                r_neg   <= rs_val[31] ^ rt_val[31];
                                r_cnt   <= CNT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_WAIT;
                            end
                            OP_MULTU: begin
                                r_mul_x <= rs_val;
                                r_mul_y <= rt_val;
                                r_neg   <= 1'b0;
                                r_cnt   <= CNT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= S_WAIT;
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_WAIT: begin
                    // Requests arriving now are dropped; the pipeline stalls on busy
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_hi    <= w_result[63:32];
                        r_lo    <= w_result[31:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_x = r_mul_x;
    assign mul_y = r_mul_y;
    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
